// File: rtl/top_mul_rr_sched_if.sv
// top_mul_rr_sched_if: requester, response and shared-multiplier signals of the round-robin multiply scheduler.
interface top_mul_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int A_W   = 13,
  parameter int B_W   = 6,
  parameter int P_W   = A_W + B_W
);
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic [N_REQ-1:0]     req_ready;
  logic                 mul_ce;
  logic [A_W-1:0]       mul_din0;
  logic [B_W-1:0]       mul_din1;
  logic [P_W-1:0]       mul_dout;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [P_W-1:0]       rsp_p;
  logic                 busy;
  modport master (
    input  req_valid, req_a, req_b, rsp_ready, mul_dout,
    output req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_p, busy
  );
  modport slave (
    output req_valid, req_a, req_b, rsp_ready, mul_dout,
    input  req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/top_mul_rr_sched.sv
// top_mul_rr_sched: round-robin arbiter feeding four requesters into one shared 2-stage multiplier with an ID tag pipeline.
module top_mul_rr_sched #(
  parameter int N_REQ = 4,
  parameter int A_W   = 13,
  parameter int B_W   = 6
) (
  input logic clk,
  input logic reset,
  top_mul_rr_sched_if.master bus
);
  logic v1, v2, ce, hit, grant;
  logic [1:0] id1, id2, rr_ptr, win, idx;
  always_comb begin
    hit = 1'b0;
    win = rr_ptr;
    idx = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (bus.req_valid[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end
  assign ce            = (~v2 | bus.rsp_ready) & ~reset;
  assign grant         = hit & ce;
  assign bus.mul_ce    = ce;
  assign bus.req_ready = grant ? N_REQ'(1) << win : '0;
  assign bus.mul_din0  = grant ? bus.req_a[win*A_W +: A_W] : '0;
  assign bus.mul_din1  = grant ? bus.req_b[win*B_W +: B_W] : '0;
  assign bus.rsp_valid = v2 & ~reset;
  assign bus.rsp_id    = id2;
  assign bus.rsp_p     = bus.mul_dout;
  assign bus.busy      = (v1 | v2) & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      id1    <= '0;
      id2    <= '0;
      rr_ptr <= '0;
    end else if (ce) begin
      v1     <= grant;
      id1    <= grant ? win : id1;
      v2     <= v1;
      id2    <= id1;
      rr_ptr <= grant ? win + 2'd1 : rr_ptr;
    end
  end
endmodule

// File: doc/top_mul_rr_sched.md
TOP_MUL_RR_SCHED -- requirements
Module: top_mul_rr_sched

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters; fixed at 4 (2-bit requester ID).
REQ-002 Parameter: A_W, 13, multiplicand width.
REQ-003 Parameter: B_W, 6, multiplier width.
REQ-004 Parameter: P_W, 19, product width, equal to A_W+B_W.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  4  per-requester operand-valid.
REQ-008 req_a  in  4*13  operand A, requester i at bits [13*i+12:13*i].
REQ-009 req_b  in  4*6  operand B, requester i at bits [6*i+5:6*i].
REQ-010 req_ready  out  4  one-hot grant/accept; operands taken when valid&ready.
REQ-011 mul_ce  out  1  clock enable to shared 2-stage unsigned multiplier.
REQ-012 mul_din0  out  13  operand A to multiplier.
REQ-013 mul_din1  out  6  operand B to multiplier.
REQ-014 mul_dout  in  19  multiplier product, registered, 2 ce-cycles after operands.
REQ-015 rsp_valid  out  1  result valid.
REQ-016 rsp_ready  in  1  result accepted by consumer.
REQ-017 rsp_id  out  2  requester ID owning the result.
REQ-018 rsp_p  out  19  product; wired directly from mul_dout.
REQ-019 busy  out  1  high while any operation is in flight (v1|v2).

Function
REQ-020 Tag pipeline SHALL mirror the multiplier: stage1 (v1,id1), stage2 (v2,id2), both advancing only when mul_ce=1.
REQ-021 mul_ce SHALL equal (~v2 | rsp_ready) & ~reset; with mul_ce=0, multiplier and tag pipeline hold.
REQ-022 rsp_valid SHALL equal v2 and rsp_id SHALL equal id2; rsp_p SHALL equal mul_dout.
REQ-023 Arbitration SHALL be round-robin over req_valid, starting search at pointer rr_ptr (2 bits), ascending, wrapping 3->0.
REQ-024 At most one req_ready bit SHALL be high per cycle; req_ready[i]=1 only if req_valid[i]=1, i is the winner, mul_ce=1, reset=0.
REQ-025 When no req_valid is set, or mul_ce=0, req_ready SHALL be 0000 and no grant SHALL occur.
REQ-026 On grant to i: mul_din0/mul_din1 SHALL carry requester i operands that cycle; v1<=1, id1<=i; rr_ptr<=(i+1) mod 4.
REQ-027 With mul_ce=1 and no grant: v1<=0; mul_din0/mul_din1 SHALL be 0.
REQ-028 With mul_ce=1: v2<=v1, id2<=id1.
REQ-029 Latency: grant in cycle T with no stalls -> rsp_valid=1 in cycle T+2 with product of granted operands.
REQ-030 Throughput: one grant per cycle while rsp_ready=1; back-to-back results in consecutive cycles, issue order preserved.
REQ-031 Stall: rsp_valid=1 & rsp_ready=0 SHALL freeze all state (v1,v2,ids,rr_ptr, multiplier); rsp_p/rsp_id stable until accepted.
REQ-032 Simultaneous accept and grant (v2=1, rsp_ready=1, new grant) SHALL complete in the same cycle with no bubble.
REQ-033 rr_ptr SHALL change only on a grant.
REQ-034 Requester inputs need not be held after their grant cycle.
REQ-035 Multiplier reset port SHALL be driven from reset.

Reset
REQ-036 With reset=1 at a clk edge: v1=0, v2=0, id1=0, id2=0, rr_ptr=0.
REQ-037 During reset: req_ready=0000, mul_ce=0, rsp_valid=0, busy=0; mul_din0/din1=0.
REQ-038 Reset mid-operation SHALL discard all in-flight results; no rsp_valid for pre-reset grants.
REQ-039 First cycle after reset deasserts, requester 0 has highest priority.

Verification
REQ-040 Single op: req_valid=0001, a=100, b=50, rsp_ready=1 -> req_ready=0001 at T, rsp_valid at T+2, rsp_id=0, rsp_p=5000.
REQ-041 Full contention: req_valid=1111 held, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence identical, offset by 2 cycles.
REQ-042 Max values: a=8191, b=63 on requester 3 -> rsp_p=516033, rsp_id=3.
REQ-043 Backpressure: two grants then rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_p/rsp_id unchanged, req_ready=0000, busy=1; on release, both results drain in consecutive cycles in order.
REQ-044 Skip idle: rr_ptr=1, req_valid=1001 -> grant 3 (not 0), then rr_ptr=0 -> next grant 0.
REQ-045 Reset mid-flight: grants at T and T+1, reset=1 at T+1 -> rsp_valid never asserts, busy=0 and rr_ptr=0 after reset.
